// File: rtl/reg_bank_alu_p.sv
// reg_bank_alu_p: small register bank feeding a multi-cycle ALU.
//
// Operand A comes from the port and the second operand from reg[reg_sel].
// ADD, SUB and AND take one cycle. MUL is an unsigned shift-add that takes
// DW cycles. The result is held in HOLD until the consumer asserts out_ready.
//
// Build option: define REGBANK_MUL_EN to build the shift-add multiplier and
// the MUL state. Without that define, opcode 11 completes in one cycle with
// data_out=0 and err_out=1.
module reg_bank_alu_p #(
    parameter  int DW   = 16,
    parameter  int NREG = 4,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_reg,
    input  logic [AW-1:0]   addr,
    input  logic [DW-1:0]   data_in,
    input  logic            valid_ula,
    input  logic [DW-1:0]   A,
    input  logic [AW-1:0]   reg_sel,
    input  logic [1:0]      instru,
    output logic            ready_ula,
    output logic [2*DW-1:0] data_out,
    output logic            valid_out,
    input  logic            out_ready,
    output logic            err_out
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_MUL = 2'b11;

`ifdef REGBANK_MUL_EN
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        HOLD = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd2
    } state_t;
`endif

    state_t          state_q, state_d;
    logic [2*DW-1:0] res_q, res_d;
    logic            err_q, err_d;
    logic [DW-1:0]   regs_q [NREG];
    logic [DW-1:0]   regs_d [NREG];

`ifdef REGBANK_MUL_EN
    // The multiplicand is pre-widened so that shifting never drops product bits.
    logic [2*DW-1:0] mcand_q, mcand_d;
    logic [DW-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]   cnt_q, cnt_d;
`endif

    logic [DW-1:0]   opnd;
    logic            sel_bad;

    // Read the second operand. Out-of-range indices read as zero and flag an error.
    always_comb begin
        opnd    = '0;
        sel_bad = 1'b1;
        for (int i = 0; i < NREG; i++) begin
            if (int'(reg_sel) == i) begin
                opnd    = regs_q[i];
                sel_bad = 1'b0;
            end
        end
    end

    // Compute the next state, register-bank writes and the result datapath.
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        err_d   = err_q;
        regs_d  = regs_q;
`ifdef REGBANK_MUL_EN
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
`endif

        // A write index that matches no register is dropped.
        // The ALU reads regs_q, so a write that collides with an accept is seen
        // only by later operations.
        for (int i = 0; i < NREG; i++) begin
            if (valid_reg && (int'(addr) == i)) begin
                regs_d[i] = data_in;
            end
        end

        case (state_q)
            IDLE: begin
                if (valid_ula) begin
                    err_d   = sel_bad;
                    state_d = HOLD;
                    case (instru)
                        OP_ADD: res_d = {{DW{1'b0}}, A} + {{DW{1'b0}}, opnd};
                        OP_SUB: res_d = {{DW{1'b0}}, A} - {{DW{1'b0}}, opnd};
                        OP_AND: res_d = {{DW{1'b0}}, A & opnd};
                        OP_MUL: begin
`ifdef REGBANK_MUL_EN
                            res_d    = '0;
                            mcand_d  = {{DW{1'b0}}, A};
                            mplier_d = opnd;
                            cnt_d    = '0;
                            state_d  = MUL;
`else
                            res_d = '0;
                            err_d = 1'b1;
`endif
                        end
                        default: res_d = '0;
                    endcase
                end
            end
`ifdef REGBANK_MUL_EN
            MUL: begin
                // One bit of the multiplier per cycle, using only latched operands.
                if (mplier_q[0]) begin
                    res_d = res_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(DW - 1)) begin
                    state_d = HOLD;
                end
            end
`endif
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, result and register-bank flops. Reset clears everything, including the bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            res_q   <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
`ifdef REGBANK_MUL_EN
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            err_q   <= err_d;
            regs_q  <= regs_d;
`ifdef REGBANK_MUL_EN
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

    // Outputs are forced low while rst is high, including the cycle before the reset edge.
    always_comb begin
        ready_ula = (state_q == IDLE) && !rst;
        valid_out = (state_q == HOLD) && !rst;
        data_out  = rst ? '0 : res_q;
        err_out   = rst ? 1'b0 : err_q;
    end

endmodule
